uart_tx: RTL



---
 rtl/uart_tx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART serial transmitter: one-entry holding register feeding a start/data/stop shifter.
// Each `tick` marks one bit period. Optional parity bit is compiled in with the macro
// UART_TX_PARITY_EN (PARITY_ODD selects odd parity then; ignored otherwise).
module uart_tx #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam logic [3:0] BitLast  = 4'(DATA_BITS - 1);
   localparam logic [1:0] StopLast = 2'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e                 state_q, state_d;
   logic [DATA_BITS-1:0]   hold_q, hold_d;
   logic                   hold_full_q, hold_full_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic [1:0]             stop_cnt_q, stop_cnt_d;
   logic                   tx_q, tx_d;
   logic                   done_q, done_d;
`ifdef UART_TX_PARITY_EN
   logic                   parity_q, parity_d;
`endif

   assign in_ready = !hold_full_q;
   assign tx       = tx_q;
   assign busy     = (state_q != StIdle);
   assign done     = done_q;

   // State register; reset drives the line idle and discards any held byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         stop_cnt_q  <= '0;
         tx_q        <= 1'b1;
         done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         tx_q        <= tx_d;
         done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   // Next state: handshake on any cycle, frame progress only on tick.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      tx_d        = tx_q;
      done_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif

      // Accept needs an empty holder and load needs a full one, so they never collide.
      if (in_valid && !hold_full_q) begin
         hold_d      = in_data;
         hold_full_d = 1'b1;
      end

      if (tick) begin
         unique case (state_q)
            StIdle: begin
               if (hold_full_q) begin
                  shift_d     = hold_q;
                  hold_full_d = 1'b0;
                  tx_d        = 1'b0;
                  state_d     = StStart;
`ifdef UART_TX_PARITY_EN
                  parity_d    = (^hold_q) ^ PARITY_ODD;
`endif
               end else begin
                  tx_d = 1'b1;
               end
            end
            StStart: begin
               tx_d      = shift_q[0];
               bit_cnt_d = '0;
               state_d   = StData;
            end
            StData: begin
               if (bit_cnt_q == BitLast) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = StParity;
`else
                  tx_d       = 1'b1;
                  stop_cnt_d = '0;
                  state_d    = StStop;
`endif
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  tx_d      = shift_q[1];
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
               tx_d       = 1'b1;
               stop_cnt_d = '0;
               state_d    = StStop;
            end
`endif
            StStop: begin
               if (stop_cnt_q != StopLast) begin
                  stop_cnt_d = stop_cnt_q + 2'd1;
                  tx_d       = 1'b1;
               end else begin
                  done_d = 1'b1;
                  if (hold_full_q) begin
                     // Back-to-back: next start bit follows the last stop bit directly.
                     shift_d     = hold_q;
                     hold_full_d = 1'b0;
                     tx_d        = 1'b0;
                     state_d     = StStart;
`ifdef UART_TX_PARITY_EN
                     parity_d    = (^hold_q) ^ PARITY_ODD;
`endif
                  end else begin
                     tx_d    = 1'b1;
                     state_d = StIdle;
                  end
               end
            end
            default: begin
               tx_d    = 1'b1;
               state_d = StIdle;
            end
         endcase
      end
   end

endmodule
